// File: rtl/ether_rx.sv
// rtl/ether_rx.sv - RMII receive framer: preamble/SFD hunt, address filter, header capture,
// payload stream through a 4-byte FCS-stripping delay line, inline CRC-32 frame check.
module ether_rx #(
  parameter logic [47:0] FPGA_MAC_ADDR    = 48'h11_11_11_11_11_11,
  parameter int unsigned PREAMBLE_MIN     = 16,
  parameter bit          ACCEPT_BROADCAST = 1'b1
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        crsdv_in,
  input  logic [1:0]  rxd_in,
  output logic [7:0]  data_out,
  output logic        data_valid_out,
  output logic [47:0] src_mac_out,
  output logic [15:0] ethertype_out,
  output logic        frame_done_out,
  output logic        frame_ok_out,
  output logic        busy_out
);
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  typedef enum logic [2:0] {IDLE, PREAMBLE, HEADER, PAYLOAD, DROP} state_t;

  state_t        state_q, state_d;
  logic [5:0]    pre_cnt_q, pre_cnt_d;
  logic [1:0]    dib_cnt_q, dib_cnt_d;
  logic [5:0]    sh_q, sh_d;
  logic [31:0]   crc_q, crc_d;
  logic [10:0]   byte_cnt_q, byte_cnt_d;
  logic [2:0]    pay_cnt_q, pay_cnt_d;
  logic [55:0]   hdr_q, hdr_d;
  logic [31:0]   dly_q, dly_d;
  logic [7:0]    data_q, data_d;
  logic          data_valid_q, data_valid_d;
  logic [47:0]   src_q, src_d;
  logic [15:0]   type_q, type_d;
  logic          done_q, done_d;
  logic          ok_q, ok_d;
  logic          busy_q, busy_d;
  logic [7:0]    rx_byte;
  logic [47:0]   dest_word;
  logic          dest_match;

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  // sh_q holds the three earlier dibits of the byte, oldest in the low bits
  assign rx_byte    = {rxd_in, sh_q};
  assign dest_word  = {hdr_q[39:0], rx_byte};
  assign dest_match = (dest_word == FPGA_MAC_ADDR) || (ACCEPT_BROADCAST && (dest_word == '1));

  always_comb begin
    state_d      = state_q;
    pre_cnt_d    = pre_cnt_q;
    dib_cnt_d    = dib_cnt_q;
    sh_d         = sh_q;
    crc_d        = crc_q;
    byte_cnt_d   = byte_cnt_q;
    pay_cnt_d    = pay_cnt_q;
    hdr_d        = hdr_q;
    dly_d        = dly_q;
    data_d       = data_q;
    data_valid_d = 1'b0;
    src_d        = src_q;
    type_d       = type_q;
    done_d       = 1'b0;
    ok_d         = ok_q;
    case (state_q)
      IDLE: begin
        if (crsdv_in && rxd_in == 2'b01) begin
          pre_cnt_d = 6'd1;
          state_d   = PREAMBLE;
        end
      end
      PREAMBLE: begin
        if (crsdv_in && rxd_in == 2'b01) begin
          if (pre_cnt_q != 6'd63) pre_cnt_d = pre_cnt_q + 6'd1;
        end else if (crsdv_in && rxd_in == 2'b11 && {26'd0, pre_cnt_q} >= PREAMBLE_MIN) begin
          state_d    = HEADER;
          dib_cnt_d  = 2'd0;
          byte_cnt_d = 11'd0;
          pay_cnt_d  = 3'd0;
          crc_d      = '1;
        end else begin
          state_d = IDLE;
        end
      end
      HEADER, PAYLOAD: begin
        if (!crsdv_in) begin
          state_d = IDLE;
          // still in HEADER past byte 6 means the address already matched
          if (state_q == PAYLOAD || byte_cnt_q >= 11'd6) begin
            done_d = 1'b1;
            ok_d   = (state_q == PAYLOAD) && (crc_q == CRC_RESIDUE) &&
                     (dib_cnt_q == 2'd0) && (pay_cnt_q == 3'd4);
          end
        end else begin
          sh_d      = {rxd_in, sh_q[5:2]};
          dib_cnt_d = dib_cnt_q + 2'd1;
          if (dib_cnt_q == 2'd3) begin
            crc_d = crc32_byte(crc_q, rx_byte);
            if (byte_cnt_q == 11'h7FF) begin
              state_d = DROP;
            end else begin
              byte_cnt_d = byte_cnt_q + 11'd1;
              if (state_q == HEADER) begin
                hdr_d = {hdr_q[47:0], rx_byte};
                if (byte_cnt_q == 11'd5 && !dest_match) state_d = DROP;
                if (byte_cnt_q == 11'd13) begin
                  src_d   = hdr_q[55:8];
                  type_d  = {hdr_q[7:0], rx_byte};
                  state_d = PAYLOAD;
                end
              end else begin
                dly_d = {dly_q[23:0], rx_byte};
                if (pay_cnt_q == 3'd4) begin
                  data_d       = dly_q[31:24];
                  data_valid_d = 1'b1;
                end else begin
                  pay_cnt_d = pay_cnt_q + 3'd1;
                end
              end
            end
          end
        end
      end
      DROP: begin
        if (!crsdv_in) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == HEADER) || (state_d == PAYLOAD) || (state_d == DROP);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q      <= IDLE;
      pre_cnt_q    <= '0;
      dib_cnt_q    <= '0;
      sh_q         <= '0;
      crc_q        <= '0;
      byte_cnt_q   <= '0;
      pay_cnt_q    <= '0;
      hdr_q        <= '0;
      dly_q        <= '0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      src_q        <= '0;
      type_q       <= '0;
      done_q       <= 1'b0;
      ok_q         <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pre_cnt_q    <= pre_cnt_d;
      dib_cnt_q    <= dib_cnt_d;
      sh_q         <= sh_d;
      crc_q        <= crc_d;
      byte_cnt_q   <= byte_cnt_d;
      pay_cnt_q    <= pay_cnt_d;
      hdr_q        <= hdr_d;
      dly_q        <= dly_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      src_q        <= src_d;
      type_q       <= type_d;
      done_q       <= done_d;
      ok_q         <= ok_d;
      busy_q       <= busy_d;
    end
  end

  assign data_out       = data_q;
  assign data_valid_out = data_valid_q;
  assign src_mac_out    = src_q;
  assign ethertype_out  = type_q;
  assign frame_done_out = done_q;
  assign frame_ok_out   = ok_q;
  assign busy_out       = busy_q;
endmodule

// File: tb/tb_ether_rx.sv
// tb/tb_ether_rx.sv - directed RMII frames into ether_rx; expectations queued at issue time,
// a negedge monitor pops and compares whenever the DUT strobes a byte or a frame status.
module tb_ether_rx;
  localparam logic [47:0] MAC_US = 48'h11_11_11_11_11_11;
  localparam logic [47:0] SRC1   = 48'h88_66_5a_03_48_b0;
  localparam logic [47:0] SRC2   = 48'h02_00_00_00_00_01;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        crsdv = 1'b0;
  logic [1:0]  rxd = 2'b00;

  logic [7:0]  data_out, nb_data_out;
  logic        data_valid_out, nb_data_valid_out;
  logic [47:0] src_mac_out, nb_src_mac_out;
  logic [15:0] ethertype_out, nb_ethertype_out;
  logic        frame_done_out, nb_frame_done_out;
  logic        frame_ok_out, nb_frame_ok_out;
  logic        busy_out, nb_busy_out;

  always #10 clk = ~clk;

  ether_rx dut (
    .clk_in(clk), .rst_in(rst_n), .crsdv_in(crsdv), .rxd_in(rxd),
    .data_out(data_out), .data_valid_out(data_valid_out),
    .src_mac_out(src_mac_out), .ethertype_out(ethertype_out),
    .frame_done_out(frame_done_out), .frame_ok_out(frame_ok_out), .busy_out(busy_out)
  );

  ether_rx #(.ACCEPT_BROADCAST(1'b0)) dut_nb (
    .clk_in(clk), .rst_in(rst_n), .crsdv_in(crsdv), .rxd_in(rxd),
    .data_out(nb_data_out), .data_valid_out(nb_data_valid_out),
    .src_mac_out(nb_src_mac_out), .ethertype_out(nb_ethertype_out),
    .frame_done_out(nb_frame_done_out), .frame_ok_out(nb_frame_ok_out), .busy_out(nb_busy_out)
  );

  typedef struct packed {
    logic        ok;
    logic [47:0] src;
    logic [15:0] etype;
  } done_t;

  logic [7:0] exp_data[$];
  done_t      exp_done[$];
  logic [7:0] frm[$];
  int         checks = 0;
  int         errors = 0;
  int         nb_valid_cnt = 0;
  int         nb_done_cnt = 0;
  logic       busy_seen = 1'b0;
  done_t      mon_d;
  logic [7:0] mon_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = (r[0] ^ b[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  task automatic build_frame(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] et,
                             input int npay, input int flip_idx);
    logic [31:0] c;
    logic [31:0] fcs;
    frm.delete();
    for (int i = 0; i < 6; i++) frm.push_back(dst[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) frm.push_back(src[47-8*i -: 8]);
    frm.push_back(et[15:8]);
    frm.push_back(et[7:0]);
    for (int i = 0; i < npay; i++) frm.push_back(8'(i));
    c = '1;
    foreach (frm[i]) c = crc_byte(c, frm[i]);
    fcs = ~c;
    for (int i = 0; i < 4; i++) frm.push_back(fcs[8*i +: 8]);
    if (flip_idx >= 0) frm[14+flip_idx] = frm[14+flip_idx] ^ 8'h04;
  endtask

  task automatic push_bytes(input int n, input int flip_idx);
    for (int i = 0; i < n; i++) exp_data.push_back((i == flip_idx) ? (8'(i) ^ 8'h04) : 8'(i));
  endtask

  task automatic push_done(input logic ok, input logic [47:0] src, input logic [15:0] et);
    done_t d;
    d.ok = ok; d.src = src; d.etype = et;
    exp_done.push_back(d);
  endtask

  task automatic drive(input logic dv, input logic [1:0] d);
    @(posedge clk);
    #1;
    crsdv = dv;
    rxd   = d;
  endtask

  task automatic send_body(input int npre, input int nbytes, input int extra);
    logic [7:0] b;
    for (int i = 0; i < npre; i++) drive(1'b1, 2'b01);
    drive(1'b1, 2'b11);
    for (int i = 0; i < nbytes; i++) begin
      b = frm[i];
      for (int k = 0; k < 4; k++) drive(1'b1, b[2*k +: 2]);
    end
    b = frm[nbytes];
    for (int k = 0; k < extra; k++) drive(1'b1, b[2*k +: 2]);
  endtask

  task automatic send_frame(input int npre, input int nbytes, input int extra);
    send_body(npre, nbytes, extra);
    repeat (14) drive(1'b0, 2'b00);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (data_valid_out) begin
        if (exp_data.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_byte: got %h, no byte expected", data_out);
        end else begin
          mon_e = exp_data.pop_front();
          check("payload_byte", {56'd0, data_out}, {56'd0, mon_e});
        end
      end
      if (frame_done_out) begin
        check("bytes_pending_at_done", 64'(exp_data.size()), 64'd0);
        if (exp_done.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got frame_done ok=%0d, no frame expected", frame_ok_out);
        end else begin
          mon_d = exp_done.pop_front();
          check("frame_ok", {63'd0, frame_ok_out}, {63'd0, mon_d.ok});
          if (mon_d.ok) begin
            check("src_mac", {16'd0, src_mac_out}, {16'd0, mon_d.src});
            check("ethertype", {48'd0, ethertype_out}, {48'd0, mon_d.etype});
          end
        end
      end
      if (nb_data_valid_out) nb_valid_cnt++;
      if (nb_frame_done_out) nb_done_cnt++;
      if (busy_out) busy_seen = 1'b1;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int nbv, nbd;
    int short_pre[2];
    repeat (3) @(posedge clk);
    #1;
    check("rst_data_valid", {63'd0, data_valid_out}, 64'd0);
    check("rst_data", {56'd0, data_out}, 64'd0);
    check("rst_src_mac", {16'd0, src_mac_out}, 64'd0);
    check("rst_ethertype", {48'd0, ethertype_out}, 64'd0);
    check("rst_frame_done", {63'd0, frame_done_out}, 64'd0);
    check("rst_frame_ok", {63'd0, frame_ok_out}, 64'd0);
    check("rst_busy", {63'd0, busy_out}, 64'd0);
    rst_n = 1'b1;
    repeat (4) drive(1'b0, 2'b00);

    // good unicast frame
    build_frame(MAC_US, SRC1, 16'h0800, 46, -1);
    push_bytes(46, -1); push_done(1'b1, SRC1, 16'h0800);
    send_frame(31, frm.size(), 0);

    // payload bit error
    build_frame(MAC_US, SRC1, 16'h0800, 46, 6);
    push_bytes(46, 6); push_done(1'b0, SRC1, 16'h0800);
    send_frame(31, frm.size(), 0);

    // foreign destination is silent and leaves the header outputs alone
    build_frame(48'h22_22_22_22_22_22, SRC2, 16'h0806, 46, -1);
    send_frame(31, frm.size(), 0);
    check("keep_src_after_drop", {16'd0, src_mac_out}, {16'd0, SRC1});
    check("keep_type_after_drop", {48'd0, ethertype_out}, 64'h0800);

    build_frame(MAC_US, SRC2, 16'h0806, 46, -1);
    push_bytes(46, -1); push_done(1'b1, SRC2, 16'h0806);
    send_frame(31, frm.size(), 0);

    // broadcast: accepted here, rejected by the ACCEPT_BROADCAST=0 instance
    nbv = nb_valid_cnt; nbd = nb_done_cnt;
    build_frame(48'hFF_FF_FF_FF_FF_FF, SRC1, 16'h86DD, 46, -1);
    push_bytes(46, -1); push_done(1'b1, SRC1, 16'h86DD);
    send_frame(31, frm.size(), 0);
    check("nb_bcast_no_bytes", 64'(nb_valid_cnt - nbv), 64'd0);
    check("nb_bcast_no_done", 64'(nb_done_cnt - nbd), 64'd0);

    // too-short preambles never raise busy
    short_pre[0] = 8; short_pre[1] = 15;
    build_frame(MAC_US, SRC2, 16'h0800, 46, -1);
    foreach (short_pre[j]) begin
      busy_seen = 1'b0;
      send_frame(short_pre[j], 14, 0);
      check("short_preamble_busy", {63'd0, busy_seen}, 64'd0);
    end

    // exactly the minimum preamble is accepted
    build_frame(MAC_US, SRC2, 16'h0800, 46, -1);
    push_bytes(46, -1); push_done(1'b1, SRC2, 16'h0800);
    send_frame(16, frm.size(), 0);

    // carrier loss half-way through a payload byte
    build_frame(MAC_US, SRC2, 16'h0800, 46, -1);
    push_bytes(6, -1); push_done(1'b0, SRC2, 16'h0800);
    send_frame(31, 24, 2);

    // carrier loss in header after a matched destination, then before one
    push_done(1'b0, SRC2, 16'h0800);
    send_frame(31, 8, 0);
    send_frame(31, 4, 0);

    // oversize frame is dropped at the 2048th byte without a status pulse
    build_frame(MAC_US, SRC1, 16'h0800, 2100, -1);
    push_bytes(2029, -1);
    send_frame(31, frm.size(), 0);

    // asynchronous reset mid-payload
    build_frame(MAC_US, SRC1, 16'h0800, 46, -1);
    push_bytes(6, -1);
    send_body(31, 24, 2);
    @(negedge clk);
    check("busy_before_reset", {63'd0, busy_out}, 64'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_busy", {63'd0, busy_out}, 64'd0);
    check("async_rst_src_mac", {16'd0, src_mac_out}, 64'd0);
    check("async_rst_ethertype", {48'd0, ethertype_out}, 64'd0);
    check("async_rst_valid", {63'd0, data_valid_out}, 64'd0);
    check("async_rst_done", {63'd0, frame_done_out}, 64'd0);
    crsdv = 1'b0;
    rxd   = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) drive(1'b0, 2'b00);

    build_frame(MAC_US, SRC2, 16'h0800, 46, -1);
    push_bytes(46, -1); push_done(1'b1, SRC2, 16'h0800);
    send_frame(31, frm.size(), 0);

    repeat (20) drive(1'b0, 2'b00);
    check("bytes_left_over", 64'(exp_data.size()), 64'd0);
    check("frames_left_over", 64'(exp_done.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
